// File: rtl/md5_sched.sv
// Sequencing controller for the MD5 brute-force datapath: issues candidates to the hash core,
// compares digests against the target and reports match, exhaustion, timeout and a tried count.
module md5_sched #(
    parameter logic [7:0] MSG_LEN = 8'd40,
    parameter int         TIMEOUT = 1024
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         target_load_i,
    input  logic [127:0] target_md5_i,
    input  logic [127:0] cand_pt_i,
    input  logic         cand_ovf_i,
    output logic         cand_step_o,
    output logic         cand_clr_o,
    output logic [127:0] core_msg_o,
    output logic [7:0]   core_len_o,
    output logic         core_start_o,
    input  logic         core_ready_i,
    input  logic [127:0] core_digest_i,
    input  logic         core_valid_i,
    output logic [127:0] match_pt_o,
    output logic         found_o,
    output logic         exhausted_o,
    output logic         error_o,
    output logic         busy_o,
    output logic [31:0]  tried_o
);

    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // The watchdog is zero in the first WAIT cycle, so the last legal value is TIMEOUT-2.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FOUND = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   target_q, target_d;
    logic [127:0]   inflight_q, inflight_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic [127:0]   msg_q, msg_d;
    logic           start_q, start_d;
    logic           step_q, step_d;
    logic           clr_q, clr_d;
    logic [127:0]   match_q, match_d;
    logic           found_q, found_d;
    logic           exh_q, exh_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic [31:0]    tried_q, tried_d;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        inflight_d = inflight_q;
        wdog_d     = wdog_q;
        msg_d      = msg_q;
        start_d    = 1'b0;
        step_d     = 1'b0;
        clr_d      = 1'b0;
        match_d    = match_q;
        found_d    = found_q;
        exh_d      = exh_q;
        err_d      = err_q;
        tried_d    = tried_q;

        if (target_load_i) begin
            target_d = target_md5_i;
            clr_d    = 1'b1;
            tried_d  = 32'd0;
            found_d  = 1'b0;
            exh_d    = 1'b0;
            err_d    = 1'b0;
            match_d  = 128'd0;
            state_d  = S_ISSUE;
        end else begin
            unique case (state_q)
                S_ISSUE: begin
                    if (cand_ovf_i) begin
                        exh_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (core_ready_i) begin
                        msg_d      = cand_pt_i;
                        inflight_d = cand_pt_i;
                        start_d    = 1'b1;
                        step_d     = 1'b1;
                        wdog_d     = '0;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (core_valid_i) begin
                        if (tried_q != 32'hFFFF_FFFF) begin
                            tried_d = tried_q + 32'd1;
                        end
                        if (core_digest_i == target_q) begin
                            match_d = inflight_q;
                            found_d = 1'b1;
                            state_d = S_FOUND;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else if (wdog_q == WD_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        wdog_d = wdog_q + WDW'(1);
                    end
                end
                S_IDLE, S_FOUND, S_DONE, S_ERR: ;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            target_q   <= 128'd0;
            inflight_q <= 128'd0;
            wdog_q     <= '0;
            msg_q      <= 128'd0;
            start_q    <= 1'b0;
            step_q     <= 1'b0;
            clr_q      <= 1'b0;
            match_q    <= 128'd0;
            found_q    <= 1'b0;
            exh_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            tried_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            inflight_q <= inflight_d;
            wdog_q     <= wdog_d;
            msg_q      <= msg_d;
            start_q    <= start_d;
            step_q     <= step_d;
            clr_q      <= clr_d;
            match_q    <= match_d;
            found_q    <= found_d;
            exh_q      <= exh_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            tried_q    <= tried_d;
        end
    end

    assign cand_step_o  = step_q;
    assign cand_clr_o   = clr_q;
    assign core_msg_o   = msg_q;
    assign core_len_o   = MSG_LEN;
    assign core_start_o = start_q;
    assign match_pt_o   = match_q;
    assign found_o      = found_q;
    assign exhausted_o  = exh_q;
    assign error_o      = err_q;
    assign busy_o       = busy_q;
    assign tried_o      = tried_q;

endmodule

// File: tb/tb_md5_sched.sv
// Bench for md5_sched: counter and hash-core models around the DUT, a behavioural
// expectation model checked every cycle, plus directed scenario checks.
module tb_md5_sched;

    localparam int           TB_TO = 80;
    localparam logic [127:0] BASE  = 128'h0000_0000_0000_0000_0000_0061_6161_6161;
    localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_TERM = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         target_load = 1'b0;
    logic [127:0] target_md5 = '0;
    logic [127:0] cand_pt = BASE;
    logic         cand_ovf = 1'b0;
    logic         cand_step_o, cand_clr_o, core_start_o;
    logic [127:0] core_msg_o, match_pt_o;
    logic [7:0]   core_len_o;
    logic         core_ready;
    logic [127:0] core_digest = '0;
    logic         core_valid = 1'b0;
    logic         found_o, exhausted_o, error_o, busy_o;
    logic [31:0]  tried_o;

    md5_sched #(.MSG_LEN(8'd40), .TIMEOUT(TB_TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .target_load_i(target_load), .target_md5_i(target_md5),
        .cand_pt_i(cand_pt), .cand_ovf_i(cand_ovf),
        .cand_step_o(cand_step_o), .cand_clr_o(cand_clr_o),
        .core_msg_o(core_msg_o), .core_len_o(core_len_o), .core_start_o(core_start_o),
        .core_ready_i(core_ready), .core_digest_i(core_digest), .core_valid_i(core_valid),
        .match_pt_o(match_pt_o), .found_o(found_o), .exhausted_o(exhausted_o),
        .error_o(error_o), .busy_o(busy_o), .tried_o(tried_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in digest: any injective function of the plaintext will do.
    function automatic logic [127:0] fake_md5(input logic [127:0] pt);
        return {pt[63:0] ^ 64'h0123_4567_89AB_CDEF, pt[127:64] ^ 64'hFEDC_BA98_7654_3210} + 128'd5;
    endfunction

    // Environment: candidate counter and hash core, reacting on the falling edge.
    int           lat = 10;
    int           ovf_limit = 0;
    int           cnt = 0;
    int           core_cnt = 0;
    logic         core_busy = 1'b0;
    logic         never_valid = 1'b0;
    logic         core_kill = 1'b0;
    logic         hold_main = 1'b0;
    logic         hold_rnd = 1'b0;
    logic         rand_hold = 1'b0;
    logic [127:0] core_job = '0;
    logic [127:0] last_msg = '0;
    logic [127:0] tgt_cur = '0;
    int           n_start = 0, n_step = 0, n_clr = 0;

    assign core_ready = !core_busy && !hold_main && !hold_rnd;

    always @(negedge clk) begin
        if (cand_clr_o) begin
            cnt = 0;
            n_clr++;
        end else if (cand_step_o) begin
            cnt++;
            n_step++;
        end
        cand_pt  = BASE + 128'(cnt);
        cand_ovf = (ovf_limit != 0) && (cnt >= ovf_limit);

        core_valid  = 1'b0;
        core_digest = ($urandom_range(0, 1) == 0) ? fake_md5(tgt_cur) : {$urandom, $urandom, $urandom, $urandom};
        if (core_kill) begin
            core_busy = 1'b0;
        end else if (core_busy && !never_valid) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_valid  = 1'b1;
                core_digest = fake_md5(core_job);
                core_busy   = 1'b0;
            end
        end
        if (core_start_o) begin
            n_start++;
            last_msg  = core_msg_o;
            core_job  = core_msg_o;
            core_busy = 1'b1;
            core_cnt  = lat;
        end
        hold_rnd = rand_hold && ($urandom_range(0, 3) == 0);
    end

    // Expectation model: outputs follow from the inputs seen at each rising edge.
    int           m_ph = P_IDLE;
    int           m_age = 0;
    logic [127:0] m_tgt = '0, m_inf = '0;
    logic         e_start = 0, e_step = 0, e_clr = 0, e_found = 0, e_exh = 0, e_err = 0, e_busy = 0;
    logic [127:0] e_msg = '0, e_match = '0;
    logic [31:0]  e_tried = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = P_IDLE; m_age = 0; m_tgt = '0; m_inf = '0;
            e_start = 0; e_step = 0; e_clr = 0; e_found = 0; e_exh = 0; e_err = 0;
            e_msg = '0; e_match = '0; e_tried = '0;
        end else begin
            e_start = 0; e_step = 0; e_clr = 0;
            if (target_load) begin
                m_tgt = target_md5; e_clr = 1; e_tried = '0;
                e_found = 0; e_exh = 0; e_err = 0; e_match = '0;
                m_ph = P_ISSUE;
            end else if (m_ph == P_ISSUE) begin
                if (cand_ovf) begin
                    e_exh = 1; m_ph = P_TERM;
                end else if (core_ready) begin
                    e_msg = cand_pt; m_inf = cand_pt; e_start = 1; e_step = 1;
                    m_age = 1; m_ph = P_WAIT;
                end
            end else if (m_ph == P_WAIT) begin
                if (core_valid) begin
                    if (e_tried != 32'hFFFF_FFFF) e_tried = e_tried + 1;
                    if (core_digest == m_tgt) begin
                        e_match = m_inf; e_found = 1; m_ph = P_TERM;
                    end else begin
                        m_ph = P_ISSUE;
                    end
                end else if (m_age == TB_TO - 1) begin
                    e_err = 1; m_ph = P_TERM;
                end else begin
                    m_age++;
                end
            end
        end
        e_busy = (m_ph == P_ISSUE) || (m_ph == P_WAIT);
    end

    always @(negedge clk) begin
        chk("cand_step", 128'(cand_step_o), 128'(e_step));
        chk("cand_clr", 128'(cand_clr_o), 128'(e_clr));
        chk("core_start", 128'(core_start_o), 128'(e_start));
        chk("core_msg", core_msg_o, e_msg);
        chk("core_len", 128'(core_len_o), 128'd40);
        chk("match_pt", match_pt_o, e_match);
        chk("found", 128'(found_o), 128'(e_found));
        chk("exhausted", 128'(exhausted_o), 128'(e_exh));
        chk("error", 128'(error_o), 128'(e_err));
        chk("busy", 128'(busy_o), 128'(e_busy));
        chk("tried", 128'(tried_o), 128'(e_tried));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [127:0] t);
        target_md5  = t;
        tgt_cur     = t;
        target_load = 1'b1;
        step();
        target_load = 1'b0;
    endtask

    task automatic wait_term(input int budget, input string nm);
        int i;
        for (i = 0; i < budget; i++) begin
            if (found_o || exhausted_o || error_o) break;
            step();
        end
        n_checks++;
        if (i >= budget) begin
            n_errors++;
            $display("FAIL %s: no terminal state after %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_start(input int budget, input string nm);
        int s, i;
        s = n_start;
        for (i = 0; i < budget; i++) begin
            if (n_start != s) break;
            step();
        end
        n_checks++;
        if (i >= budget) begin
            n_errors++;
            $display("FAIL %s: no core_start after %0d cycles", nm, budget);
        end
    endtask

    initial begin
        int s0, st0, c0, k, idx;

        #2 rst_n = 1'b0;
        steps(3);
        chk("rst_core_len", 128'(core_len_o), 128'd40);
        chk("rst_busy", 128'(busy_o), 128'd0);
        rst_n = 1'b1;
        s0 = n_start;
        steps(10);
        chk("idle_no_start", 128'(n_start - s0), 128'd0);

        // Match on the third candidate.
        lat = 64; ovf_limit = 0;
        s0 = n_start;
        load(fake_md5(BASE + 128'd2));
        chk("load_clr", 128'(cand_clr_o), 128'd1);
        wait_term(1000, "match_wait");
        chk("match_found", 128'(found_o), 128'd1);
        chk("match_pt_lit", match_pt_o, 128'h0000_0000_0000_0000_0000_0061_6161_6163);
        chk("match_tried", 128'(tried_o), 128'd3);
        chk("match_starts", 128'(n_start - s0), 128'd3);
        steps(100);
        chk("match_no_more", 128'(n_start - s0), 128'd3);

        // Reset in the middle of a WAIT.
        load(fake_md5(BASE + 128'd500));
        wait_start(50, "rst_wait_start");
        steps(10);
        rst_n = 1'b0;
        step();
        chk("rst_mid_start", 128'(core_start_o), 128'd0);
        chk("rst_mid_busy", 128'(busy_o), 128'd0);
        chk("rst_mid_len", 128'(core_len_o), 128'd40);
        step();
        rst_n = 1'b1;
        s0 = n_start;
        steps(60);
        chk("rst_no_start", 128'(n_start - s0), 128'd0);

        // Exhaustion after five compares.
        lat = 10; ovf_limit = 5;
        s0 = n_start;
        load(fake_md5(BASE + 128'd100));
        wait_term(500, "exh_wait");
        chk("exh_flag", 128'(exhausted_o), 128'd1);
        chk("exh_found", 128'(found_o), 128'd0);
        chk("exh_tried", 128'(tried_o), 128'd5);
        steps(30);
        chk("exh_starts", 128'(n_start - s0), 128'd5);

        // Core timeout, and the valid-on-timeout-cycle boundary.
        never_valid = 1'b1; ovf_limit = 0;
        load(fake_md5(BASE + 128'd100));
        wait_start(50, "to_wait_start");
        k = 0;
        while (!error_o && k < 200) begin
            step();
            k++;
        end
        chk("to_cycles", 128'(k), 128'(TB_TO - 1));
        never_valid = 1'b0;
        core_kill = 1'b1;
        step();
        core_kill = 1'b0;

        lat = TB_TO - 2; ovf_limit = 1;
        load(fake_md5(BASE + 128'd100));
        wait_term(400, "to_edge_wait");
        chk("to_edge_err", 128'(error_o), 128'd0);
        chk("to_edge_exh", 128'(exhausted_o), 128'd1);
        chk("to_edge_tried", 128'(tried_o), 128'd1);

        lat = TB_TO - 1;
        load(fake_md5(BASE + 128'd100));
        wait_term(400, "to_late_wait");
        chk("to_late_err", 128'(error_o), 128'd1);
        steps(10);
        chk("to_late_tried", 128'(tried_o), 128'd0);

        // Abort mid-WAIT; the stale result lands in ISSUE and is dropped.
        lat = 30; ovf_limit = 0;
        load(fake_md5(BASE + 128'd100));
        wait_start(50, "abort_first");
        steps(5);
        c0 = n_clr;
        s0 = n_start;
        load(fake_md5(BASE + 128'd101));
        wait_start(100, "abort_restart");
        chk("abort_clr_once", 128'(n_clr - c0), 128'd1);
        chk("abort_one_start", 128'(n_start - s0), 128'd1);
        chk("abort_msg", last_msg, BASE);
        chk("abort_tried", 128'(tried_o), 128'd0);
        ovf_limit = 3;
        wait_term(500, "abort_end");
        chk("abort_tried_end", 128'(tried_o), 128'd3);

        // Back-pressure on core_ready.
        lat = 5; ovf_limit = 2;
        hold_main = 1'b1;
        s0 = n_start; st0 = n_step;
        load(fake_md5(BASE + 128'd100));
        steps(20);
        chk("bp_no_start", 128'(n_start - s0), 128'd0);
        chk("bp_no_step", 128'(n_step - st0), 128'd0);
        chk("bp_busy", 128'(busy_o), 128'd1);
        hold_main = 1'b0;
        step();
        chk("bp_start_next", 128'(core_start_o), 128'd1);
        chk("bp_step_next", 128'(cand_step_o), 128'd1);
        wait_term(200, "bp_end");

        // Randomised rounds, including random aborts and ready back-pressure.
        for (int r = 0; r < 25; r++) begin
            lat       = $urandom_range(1, 25);
            ovf_limit = $urandom_range(1, 8);
            rand_hold = $urandom_range(0, 1) == 1;
            idx       = $urandom_range(0, 9);
            load(fake_md5(BASE + 128'(idx)));
            if ($urandom_range(0, 2) == 0) begin
                steps($urandom_range(1, 60));
                idx = $urandom_range(0, 9);
                load(fake_md5(BASE + 128'(idx)));
            end
            wait_term(3000, "rand_wait");
            rand_hold = 1'b0;
            steps(30);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/md5_sched.md
# md5_sched

Sequencing controller for the MD5 brute-force datapath. It sits between the candidate counter, the pancham hash core and the serial I/O blocks, and replaces the free-running `ready & valid & !match` gating with an explicit state machine. Each candidate plaintext is latched at issue time, so the reported match is the plaintext that actually produced the digest. The block also owns the target digest, the digest comparison, exhaustion and core-timeout detection, and a hashed-candidate count.

## Interface
- `MSG_LEN`, default 8'd40: message length in bits, driven to the core.
- `TIMEOUT`, default 1024: maximum cycles in WAIT before an error (≥2).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `target_load` in 1: one-cycle pulse; `target_md5` is valid and a new search starts.
- `target_md5` in 128: digest to break, sampled on `target_load`.
- `cand_pt` in 128: current counter plaintext.
- `cand_ovf` in 1: counter has wrapped; `cand_pt` is no longer a fresh candidate.
- `cand_step` out 1: one-cycle pulse that advances the counter.
- `cand_clr` out 1: one-cycle pulse that restarts the counter at its reset value.
- `core_msg` out 128: plaintext to the hash core (registered).
- `core_len` out 8: constant `MSG_LEN`.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_ready` in 1: core idle, may accept a start.
- `core_digest` in 128: core result.
- `core_valid` in 1: `core_digest` is valid (pulse).
- `match_pt` out 128: plaintext whose digest equals the target.
- `found` out 1: sticky; a match was found.
- `exhausted` out 1: sticky; the counter wrapped with no match.
- `error` out 1: sticky; the core timed out.
- `busy` out 1: high in ISSUE and WAIT.
- `tried` out 32: number of digests compared since the last `target_load`; saturates at 0xFFFFFFFF.

## Operation
- **States:** IDLE, ISSUE, WAIT, FOUND, DONE, ERR.
- **IDLE:** outputs are quiet. `target_load` latches the target, pulses `cand_clr`, clears `tried`, `found`, `exhausted`, `error` and `match_pt`, then goes to ISSUE.
- **ISSUE:**
  - If `cand_ovf`=1, go to DONE and set `exhausted`=1 (`cand_ovf` has priority over `core_ready`).
  - Else if `core_ready`=1: `core_msg`←`cand_pt`, internal `inflight_pt`←`cand_pt`, pulse `core_start` and `cand_step`, clear the watchdog, go to WAIT.
  - Else wait.
  - `core_valid` is ignored in ISSUE; this discards results left over from an aborted job.
- **WAIT:** each cycle the watchdog increments.
  - On `core_valid`: `tried`+1 (saturating).
    - If `core_digest`==target: `match_pt`←`inflight_pt`, `found`=1, go to FOUND.
    - Otherwise go to ISSUE.
  - If `core_valid` has not arrived and the watchdog reaches `TIMEOUT`-1: `error`=1, go to ERR.
  - `core_valid` on the same cycle as the timeout: the valid wins.
- **FOUND, DONE, ERR:** terminal. Only `target_load` or reset leaves them.
- **`target_load` in any state** (including ISSUE and WAIT) does the same as in IDLE and goes to ISSUE. An in-flight core job is abandoned. Its `core_valid` either lands in ISSUE and is dropped, or the ISSUE state waits for `core_ready` before the next start.
- **`target_load` and `core_valid` in the same cycle:** `target_load` wins. No compare, no `tried` increment.
- **Width rules:** full 128-bit equality compare; the 32-bit `tried` counter never wraps.

## Timing
- **Reset (asynchronous, `rst`=0):**
  - State is IDLE.
  - All outputs are 0 except `core_len`=`MSG_LEN`.
  - Internal target, `inflight_pt` and watchdog are cleared.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Issue latency:** if ISSUE samples `core_ready`=1 at edge N, then `core_start`, `cand_step` and `core_msg` are valid during cycle N+1, and state is WAIT from N+1.
  - `core_start` is exactly one cycle wide.
  - One `cand_step` per `core_start`.
- **Result latency:** `core_valid` sampled at edge M gives `found`/`match_pt`/`tried` updates visible in cycle M+1. The next `core_start` comes no earlier than cycle M+2.
- **Outstanding jobs:** at most one core job in flight.
- **Restart latency:** `target_load` at edge K gives `cand_clr` high in cycle K+1 and state ISSUE in K+1. The first `core_start` is no earlier than K+2, so the counter has cleared first.
- **`busy`:** follows the state register in the same cycle.

## Test plan
- **Reset:** assert `rst`=0 mid-WAIT → all outputs 0, state IDLE, `core_len`=40. Release → no `core_start` until `target_load`.
- **Match:** target = MD5 of the 3rd candidate; core model gives `core_valid` 64 cycles after each start → exactly 3 `core_start` pulses; `found`=1, `match_pt`=3rd `cand_pt`, `tried`=3, no further `core_start`.
- **Exhaustion:** raise `cand_ovf` after 5 compares, no match → `exhausted`=1, `found`=0, `tried`=5, no 6th start.
- **Timeout:** `TIMEOUT`=16, core never asserts `core_valid` → `error`=1 exactly 15 cycles after the first WAIT cycle. With `core_valid` on that same cycle → no error, compare proceeds.
- **Abort:** `target_load` in WAIT, then the stale `core_valid` arrives while in ISSUE → stale result dropped, `tried`=0, `cand_clr` pulsed once, next start uses the cleared `cand_pt`.
- **Back-pressure:** hold `core_ready`=0 for 20 cycles in ISSUE → no `core_start` or `cand_step`. Start issues one cycle after `core_ready` rises.
